// File: rtl/alu_seq.sv
// Registered ALU: single-cycle AND/XOR/SUB and an iterative shift-add MUL behind a start/ready/done handshake.
// Optional macro ALU_OVERFLOW_EN adds the registered signed-overflow output ovf.
module alu_seq #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] R,
    output logic             zero,
    output logic             neg,
    output logic             carry
`ifdef ALU_OVERFLOW_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_XOR = 2'b01;
    localparam logic [1:0] OP_SUB = 2'b10;
    localparam logic [1:0] OP_MUL = 2'b11;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

    state_t             state_r;
    logic [2*WIDTH-1:0] mcand_r;
    logic [WIDTH-1:0]   mplier_r;
    logic [2*WIDTH-1:0] acc_r;
    logic [CW-1:0]      count_r;

    logic [WIDTH:0]     sub_full_s;
    logic [WIDTH-1:0]   op_res_s;
    logic               op_carry_s;
    logic [2*WIDTH-1:0] acc_next_s;

    // Flags are always derived from the value being loaded into R.
    function automatic logic is_zero(input logic [WIDTH-1:0] v);
        return (v == '0);
    endfunction

    // Single-cycle result and borrow for the non-multiply opcodes
    always_comb begin
        sub_full_s = {1'b0, A} - {1'b0, B};
        op_res_s   = '0;
        op_carry_s = 1'b0;
        case (Op)
            OP_AND: op_res_s = A & B;
            OP_XOR: op_res_s = A ^ B;
            OP_SUB: begin
                op_res_s   = sub_full_s[WIDTH-1:0];
                op_carry_s = sub_full_s[WIDTH];
            end
            default: begin
                op_res_s   = '0;
                op_carry_s = 1'b0;
            end
        endcase
    end

`ifdef ALU_OVERFLOW_EN
    logic op_ovf_s;

    // Signed overflow of the subtraction; zero for the logic opcodes
    always_comb begin
        op_ovf_s = 1'b0;
        if (Op == OP_SUB) begin
            op_ovf_s = (A[WIDTH-1] != B[WIDTH-1]) && (sub_full_s[WIDTH-1] != A[WIDTH-1]);
        end else begin
            op_ovf_s = 1'b0;
        end
    end
`endif

    // Accumulator value after this multiply step
    always_comb begin
        acc_next_s = acc_r;
        if (mplier_r[0]) begin
            acc_next_s = acc_r + mcand_r;
        end else begin
            acc_next_s = acc_r;
        end
    end

    // Control FSM, multiply datapath and registered result/flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            mcand_r  <= '0;
            mplier_r <= '0;
            acc_r    <= '0;
            count_r  <= '0;
            R        <= '0;
            zero     <= 1'b0;
            neg      <= 1'b0;
            carry    <= 1'b0;
            done     <= 1'b0;
            ready    <= 1'b1;
`ifdef ALU_OVERFLOW_EN
            ovf      <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start && (Op == OP_MUL)) begin
                        mcand_r  <= {{WIDTH{1'b0}}, A};
                        mplier_r <= B;
                        acc_r    <= '0;
                        count_r  <= CW'(WIDTH);
                        state_r  <= ST_MUL;
                        ready    <= 1'b0;
                    end else if (start) begin
                        R     <= op_res_s;
                        zero  <= is_zero(op_res_s);
                        neg   <= op_res_s[WIDTH-1];
                        carry <= op_carry_s;
                        done  <= 1'b1;
`ifdef ALU_OVERFLOW_EN
                        ovf   <= op_ovf_s;
`endif
                    end else begin
                        ready <= 1'b1;
                    end
                end
                ST_MUL: begin
                    acc_r    <= acc_next_s;
                    mcand_r  <= mcand_r << 1;
                    mplier_r <= mplier_r >> 1;
                    count_r  <= count_r - CW'(1);
                    // Last step: publish the truncated product; a start seen here is dropped.
                    if (count_r == CW'(1)) begin
                        R       <= acc_next_s[WIDTH-1:0];
                        zero    <= is_zero(acc_next_s[WIDTH-1:0]);
                        neg     <= acc_next_s[WIDTH-1];
                        carry   <= |acc_next_s[2*WIDTH-1:WIDTH];
                        done    <= 1'b1;
                        state_r <= ST_IDLE;
                        ready   <= 1'b1;
`ifdef ALU_OVERFLOW_EN
                        ovf     <= |acc_next_s[2*WIDTH-1:WIDTH];
`endif
                    end else begin
                        ready <= 1'b0;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    ready   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed vector table, handshake corner sequences
// and random operations checked against an arithmetic reference model.
module tb_alu_seq;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [1:0]   Op;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         ready;
    logic         done;
    logic [W-1:0] R;
    logic         zero;
    logic         neg;
    logic         carry;
`ifdef ALU_OVERFLOW_EN
    logic         ovf;
`endif

    int n_vec = 0;
    int n_err = 0;

    alu_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .Op    (Op),
        .A     (A),
        .B     (B),
        .ready (ready),
        .done  (done),
        .R     (R),
        .zero  (zero),
        .neg   (neg),
        .carry (carry)
`ifdef ALU_OVERFLOW_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] r;
        logic         z;
        logic         n;
        logic         c;
        logic         o;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model from the arithmetic definitions
    task automatic model(input logic [1:0] op, input int a, input int b,
                         output logic [W-1:0] r, output logic c, output logic o);
        int full;
        int half;
        int sa;
        int sb;
        int d;
        full = 1 << W;
        half = 1 << (W - 1);
        r = '0; c = 1'b0; o = 1'b0;
        case (op)
            2'b00: r = W'(a & b);
            2'b01: r = W'(a ^ b);
            2'b10: begin
                r  = W'((a - b + full) % full);
                c  = (a < b);
                sa = (a >= half) ? a - full : a;
                sb = (b >= half) ? b - full : b;
                d  = sa - sb;
                o  = (d < -half) || (d > half - 1);
            end
            default: begin
                r = W'((a * b) % full);
                c = ((a * b) >= full);
                o = c;
            end
        endcase
    endtask

    // Waits for done after a start edge; lat = edges counted after the start edge
    task automatic wait_done(output int lat);
        lat = 0;
        while (done !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic check_outs(input string tag, input logic [W-1:0] er, input logic ez,
                              input logic en, input logic ec, input logic eo);
        chk({tag, ".done"}, done, 1'b1);
        chk({tag, ".R"}, R, er);
        chk({tag, ".zero"}, zero, ez);
        chk({tag, ".neg"}, neg, en);
        chk({tag, ".carry"}, carry, ec);
        chk({tag, ".ready"}, ready, 1'b1);
`ifdef ALU_OVERFLOW_EN
        chk({tag, ".ovf"}, ovf, eo);
`else
        if (eo === 1'bx) $display("unexpected unknown ovf expectation in %s", tag);
`endif
    endtask

    task automatic do_op(input string tag, input logic [1:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] er, input logic ez,
                         input logic en, input logic ec, input logic eo);
        int lat;
        @(negedge clk);
        start = 1'b1; Op = op; A = a; B = b;
        @(posedge clk); #1;
        start = 1'b0;
        if (op == 2'b11) begin
            chk({tag, ".ready_low"}, ready, 1'b0);
            wait_done(lat);
            chk({tag, ".latency"}, lat, W);
        end
        check_outs(tag, er, ez, en, ec, eo);
        @(posedge clk); #1;
        chk({tag, ".done_pulse"}, done, 1'b0);
    endtask

    vec_t tbl[10];

    initial begin
        int lat;
        int ndone;
        logic [W-1:0] er;
        logic ec;
        logic eo;

        rst = 1'b1; start = 1'b0; Op = 2'b00; A = '0; B = '0;
        #12;
        chk("reset.R", R, 4'h0);
        chk("reset.flags", {zero, neg, carry, done}, 4'b0000);
        chk("reset.ready", ready, 1'b1);
        @(negedge clk);
        rst = 1'b0;

        //            op     a      b      r      z     n     c     o
        tbl[0] = '{2'b00, 4'hC, 4'hA, 4'h8, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{2'b01, 4'h5, 4'h5, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{2'b01, 4'hC, 4'hA, 4'h6, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{2'b10, 4'h5, 4'h3, 4'h2, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{2'b10, 4'h2, 4'h4, 4'hE, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[5] = '{2'b10, 4'h8, 4'h1, 4'h7, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[6] = '{2'b11, 4'h3, 4'h2, 4'h6, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[7] = '{2'b11, 4'hF, 4'hF, 4'h1, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[8] = '{2'b11, 4'hF, 4'h1, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[9] = '{2'b11, 4'h0, 4'h9, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 10; i++) begin
            do_op($sformatf("tbl%0d", i), tbl[i].op, tbl[i].a, tbl[i].b,
                  tbl[i].r, tbl[i].z, tbl[i].n, tbl[i].c, tbl[i].o);
        end

        // Back-to-back XORs on consecutive edges
        @(negedge clk);
        start = 1'b1; Op = 2'b01; A = 4'h5; B = 4'h5;
        @(posedge clk); #1;
        check_outs("b2b0", 4'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        A = 4'hC; B = 4'hA;
        @(posedge clk); #1;
        start = 1'b0;
        check_outs("b2b1", 4'h6, 1'b0, 1'b0, 1'b0, 1'b0);

        // Starts and operand changes during MUL are ignored
        @(negedge clk);
        start = 1'b1; Op = 2'b11; A = 4'h3; B = 4'h3;
        @(negedge clk);
        start = 1'b1; Op = 2'b00; A = 4'hF; B = 4'hF;
        @(negedge clk);
        start = 1'b0; Op = 2'b01; A = 4'h7; B = 4'hC;
        wait_done(lat);
        chk("ign.latency", lat + 1, W);
        check_outs("ign", 4'h9, 1'b0, 1'b1, 1'b0, 1'b0);
        ndone = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        chk("ign.single_done", ndone, 0);

        // start held across MUL completion: dropped at that edge, accepted on the next
        @(negedge clk);
        start = 1'b1; Op = 2'b11; A = 4'h3; B = 4'h2;
        @(posedge clk); #1;
        Op = 2'b00; A = 4'hF; B = 4'h5;
        wait_done(lat);
        chk("hold.latency", lat, W);
        check_outs("hold.mul", 4'h6, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        start = 1'b0;
        check_outs("hold.and", 4'h5, 1'b0, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset in the middle of a MUL
        @(negedge clk);
        start = 1'b1; Op = 2'b11; A = 4'h3; B = 4'h3;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("arst.R", R, 4'h0);
        chk("arst.flags", {zero, neg, carry, done}, 4'b0000);
        chk("arst.ready", ready, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        chk("arst.no_done", ndone, 0);
        do_op("arst.after", 2'b00, 4'hF, 4'h3, 4'h3, 1'b0, 1'b0, 1'b0, 1'b0);

        // Random operations against the reference model
        for (int i = 0; i < 150; i++) begin
            logic [1:0]   rop;
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            rop = 2'($urandom_range(0, 3));
            ra  = W'($urandom);
            rb  = W'($urandom);
            model(rop, int'(ra), int'(rb), er, ec, eo);
            do_op($sformatf("rnd%0d", i), rop, ra, rb, er, (er == '0), er[W-1], ec, eo);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Registered, parametrised successor to the 4-bit structural ALU. Operations: AND, XOR, SUB and MUL, with the same 2-bit opcode map.
- MUL is an iterative shift-add unit. AND, XOR and SUB complete in one cycle.
- Result and status flags (zero, negative, carry/borrow) are held in registers until the next operation completes.
- A start/ready/done handshake lets the FPGA controller sequence operations without fixed timing.

Parameters:
- WIDTH, 4, operand and result width in bits (≥2).

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  asynchronous reset, active-high
- start  input  1  request; sampled only when ready=1
- Op  input  2  00 AND, 01 XOR, 10 SUB, 11 MUL
- A  input  WIDTH  operand A, unsigned
- B  input  WIDTH  operand B, unsigned
- ready  output  1  idle, able to accept start
- done  output  1  one-cycle pulse: R and flags just updated
- R  output  WIDTH  result, held until next done
- zero  output  1  R == 0
- neg  output  1  R[WIDTH-1]
- carry  output  1  SUB: borrow (A<B); MUL: truncation (product ≥ 2^WIDTH); AND/XOR: 0

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- Reset values: R=0, zero=0, neg=0, carry=0, done=0, ready=1, state=IDLE, internal accumulator/counter=0.
- States: IDLE, MUL.
- IDLE, start=1 sampled at edge k, Op≠11:
  - At edge k, R and flags are loaded with the result; done=1 during cycle k..k+1. Latency is 1 cycle.
  - State stays IDLE and ready stays 1, so back-to-back starts are legal every cycle.
- IDLE, start=1 at edge k, Op=11:
  - At edge k: latch A as multiplicand (zero-extended to 2·WIDTH), latch B as multiplier, acc=0, count=WIDTH, go to MUL. ready=0 from edge k.
- MUL, each edge:
  - If multiplier[0], acc += multiplicand.
  - Then multiplicand <<= 1, multiplier >>= 1, count -= 1.
  - On the edge where count goes 1→0: R = acc_final[WIDTH-1:0], carry = |acc_final[2WIDTH-1:WIDTH], zero/neg from the new R, done=1 for one cycle, state back to IDLE, ready=1.
  - done is visible WIDTH cycles after the start edge (edge k+WIDTH).
- Arithmetic:
  - SUB: R = (A − B) mod 2^WIDTH; carry = (A < B).
  - MUL: R is the low WIDTH bits of the product (wrap-around).
  - zero and neg always reflect the R being loaded, never the combinational inputs.
- start while ready=0 is ignored. It is not queued and does not disturb the operation in flight.
- A, B and Op changing during MUL have no effect, because the operands are latched.
- Outputs R and flags hold their values between done pulses. done is never high for two consecutive cycles from a single MUL.
- rst mid-MUL: immediate abort, all reset values applied, no done pulse. The next start after rst deasserts is accepted normally.
- start sampled in the same edge that MUL completes: ignored (ready=0 at that edge). It is accepted from the next edge on.

Optional Feature:
- Macro: ALU_OVERFLOW_EN.
- Defined: adds output port ovf (1 bit), registered with R, reset value 0.
  - SUB: ovf = two's-complement signed overflow, i.e. (A[msb]≠B[msb]) && (R[msb]≠A[msb]).
  - MUL: ovf = carry.
  - AND/XOR: ovf = 0.
- Not defined: port ovf and its logic are absent. All other behaviour is unchanged.

Test Plan:
- WIDTH=4, Op=00, A=1100, B=1010, start one cycle → next cycle: done=1, R=1000, neg=1, zero=0, carry=0, ready=1.
- Op=01, A=0101, B=0101 → R=0000, zero=1, neg=0. Then back-to-back Op=01, A=1100, B=1010 on the following cycle → R=0110, done high on both cycles.
- Op=10, A=0101, B=0011 → R=0010, carry=0.
  - A=0010, B=0100 → R=1110, carry=1, neg=1.
  - With ALU_OVERFLOW_EN, A=1000, B=0001 → R=0111, ovf=1.
- Op=11, A=0011, B=0010 → ready=0 for 4 cycles, done pulses exactly 4 cycles after the start edge, R=0110, carry=0.
  - A=1111, B=1111 → R=0001, carry=1.
  - A=1111, B=0001 → R=1111, carry=0.
- During MUL (A=0011, B=0011), pulse start with Op=00, A=1111, B=1111 and change A/B → both ignored; final R=1001, single done.
- Start MUL, assert rst asynchronously 2 cycles later (mid-clock) → R, flags, done go to 0 immediately, ready=1, no done pulse. After release, Op=00, A=1111, B=0011 → R=0011 next cycle.
